reset_sequencer: RTL

Parametrised, single-clock-domain reset generator. It merges N_REQ asynchronous reset requests and one synchronous software request into N_CH reset outputs. All outputs assert together and are held for a programmable stretch. The outputs then release in a fixed order, channel 0 first, with a programmable gap between channels. It sits at the top of each clock domain and drives that domain's sub-block resets.

---
 rtl/reset_seq_pkg.sv | 28 ++
 rtl/sync_bit.sv | 23 ++
 rtl/reset_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration-time helpers for the reset sequencer.
// The counter/index width helpers and the parameter legality check live here.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } seq_state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A counter that must hold values 0..max_value-1 needs at least one bit
    function automatic int width_for(input int max_value);
        int w;
        w = $clog2(max_value);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit params_ok(input int n_req, input int n_ch, input int sync_stages,
                                     input int hold_cycles, input int gap_cycles);
        return (n_req >= 1) && (n_ch >= 1) && (sync_stages >= 2) &&
               (hold_cycles >= 1) && (gap_cycles >= 1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous bit; flops clear to 0 on reset.
module sync_bit #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Merges async and software reset requests into N_CH resets that assert together,
// hold for HOLD_CYCLES, then release channel 0 first with GAP_CYCLES spacing.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] rst_req,
    input  logic             sw_rst,
    output logic [N_CH-1:0]  rst_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = width_for(max_of(HOLD_CYCLES, GAP_CYCLES));
    localparam int IDX_W = width_for(N_CH);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_CH - 1);

    if (!params_ok(N_REQ, N_CH, SYNC_STAGES, HOLD_CYCLES, GAP_CYCLES)) begin : g_bad_params
        $error("reset_sequencer: illegal parameter combination");
    end

    logic [N_REQ-1:0] req_sync;
    logic             req_s;

    for (genvar i = 0; i < N_REQ; i++) begin : g_sync
        sync_bit #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (rst_req[i]),
            .q     (req_sync[i])
        );
    end

    assign req_s = (|req_sync) | sw_rst;

    seq_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [N_CH-1:0]  rst_out_n;
    logic             done_n;

    // Reset lands in HOLD with a full count, so power-on runs the whole sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HOLD;
            cnt     <= HOLD_LOAD;
            idx     <= '0;
            rst_out <= '1;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            rst_out <= rst_out_n;
            done    <= done_n;
        end
    end

    // A request always wins over counter events and re-asserts every channel
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        rst_out_n = rst_out;
        done_n    = 1'b0;
        case (state)
            HOLD: begin
                if (req_s) begin
                    cnt_n = HOLD_LOAD;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CNT_ONE;
                end else begin
                    rst_out_n[0] = 1'b0;
                    cnt_n        = GAP_LOAD;
                    idx_n        = IDX_ONE;
                    if (N_CH == 1) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (req_s) begin
                    rst_out_n = '1;
                    cnt_n     = HOLD_LOAD;
                    state_n   = HOLD;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CNT_ONE;
                end else begin
                    rst_out_n[idx] = 1'b0;
                    cnt_n          = GAP_LOAD;
                    if (idx == IDX_LAST) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        idx_n = idx + IDX_ONE;
                    end
                end
            end
            IDLE: begin
                if (req_s) begin
                    rst_out_n = '1;
                    cnt_n     = HOLD_LOAD;
                    state_n   = HOLD;
                end
            end
            default: begin
                rst_out_n = '1;
                cnt_n     = HOLD_LOAD;
                state_n   = HOLD;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
